// File: rtl/add_32bit_seq.sv
// Byte-serial 32-bit adder: Z = X + Y + C_IN (mod 2^32) with carry out; optional V port when ADD_OVERFLOW_EN is defined.
// Latency: 4 cycles from the START sample edge to the DONE pulse; back-to-back issue leaves one idle cycle between operations.
// Backpressure: START is only sampled while idle; any request while BUSY is high is dropped without effect.
module add_32bit_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        C_IN,
  output logic [31:0] Z,
  output logic        C_OUT,
  output logic        BUSY,
  output logic        DONE
`ifdef ADD_OVERFLOW_EN
  ,
  output logic        V
`endif
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic        r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic        r_carry;
  logic [23:0] r_acc;

  logic [7:0]  w_xb;
  logic [7:0]  w_yb;
  logic [8:0]  w_sum;
  logic        w_last;

  // Select the operand byte addressed by the counter and add it with the running carry.
  always_comb begin
    w_xb = 8'd0;
    w_yb = 8'd0;
    case (r_cnt)
      2'd0: begin w_xb = r_x[7:0];   w_yb = r_y[7:0];   end
      2'd1: begin w_xb = r_x[15:8];  w_yb = r_y[15:8];  end
      2'd2: begin w_xb = r_x[23:16]; w_yb = r_y[23:16]; end
      default: begin w_xb = r_x[31:24]; w_yb = r_y[31:24]; end
    endcase
    w_sum  = {1'b0, w_xb} + {1'b0, w_yb} + {8'd0, r_carry};
    w_last = (r_state == S_RUN) && (r_cnt == 2'd3);
  end

  // Sequencer and datapath: latch operands on START, then accumulate one byte per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_x     <= 32'd0;
      r_y     <= 32'd0;
      r_carry <= 1'b0;
      r_acc   <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_x     <= X;
            r_y     <= Y;
            r_carry <= C_IN;
            r_cnt   <= 2'd0;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_carry <= w_sum[8];
          r_cnt   <= r_cnt + 2'd1;
          case (r_cnt)
            2'd0:    r_acc[7:0]   <= w_sum[7:0];
            2'd1:    r_acc[15:8]  <= w_sum[7:0];
            2'd2:    r_acc[23:16] <= w_sum[7:0];
            default: r_state      <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  // Visible outputs: result registers change only on the final byte so Z never shows a partial sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Z     <= 32'd0;
      C_OUT <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef ADD_OVERFLOW_EN
      V     <= 1'b0;
`endif
    end else begin
      DONE <= w_last;
      if ((r_state == S_IDLE) && START) begin
        BUSY <= 1'b1;
      end else if (w_last) begin
        BUSY <= 1'b0;
      end
      if (w_last) begin
        Z     <= {w_sum[7:0], r_acc};
        C_OUT <= w_sum[8];
`ifdef ADD_OVERFLOW_EN
        // Signed overflow: operands share a sign that the result does not.
        V     <= (r_x[31] == r_y[31]) && (w_sum[7] != r_x[31]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_add_32bit_seq.sv
// Directed bench for add_32bit_seq: latency, hold of Z, back-to-back issue, busy-drop and reset abort.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define ADD_OVERFLOW_EN to also check the V port.
module tb_add_32bit_seq;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] X;
  logic [31:0] Y;
  logic        C_IN;
  logic [31:0] Z;
  logic        C_OUT;
  logic        BUSY;
  logic        DONE;
`ifdef ADD_OVERFLOW_EN
  logic        V;
`endif

  int n_checks;
  int n_errors;

  logic [31:0] last_z;
  logic        last_c;

  add_32bit_seq dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .X     (X),
    .Y     (Y),
    .C_IN  (C_IN),
    .Z     (Z),
    .C_OUT (C_OUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
`ifdef ADD_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge. Issues one addition and stops at the falling edge of the DONE cycle,
  // so an immediate second call exercises back-to-back issue.
  task automatic do_add(input logic [31:0] x, input logic [31:0] y, input logic cin,
                        input logic [31:0] ez, input logic ec, input logic ev, input bit poke);
    X = x; Y = y; C_IN = cin; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    // Scramble inputs after sampling: result must depend only on latched values.
    X = ~x; Y = 32'h5A5A_5A5A; C_IN = ~cin;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
    chk("done_low_after_start", {31'd0, DONE}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (poke && i == 0) begin
        START = 1'b1; X = 32'hFFFF_FFFF; Y = 32'hFFFF_FFFF; C_IN = 1'b1;
      end
      @(negedge CLK);
      START = 1'b0;
      chk("done_low_running", {31'd0, DONE}, 32'd0);
      chk("busy_running", {31'd0, BUSY}, 32'd1);
      chk("z_holds_running", Z, last_z);
      chk("c_holds_running", {31'd0, C_OUT}, {31'd0, last_c});
    end
    @(negedge CLK);
    chk("done_pulse", {31'd0, DONE}, 32'd1);
    chk("busy_fell", {31'd0, BUSY}, 32'd0);
    chk("z_result", Z, ez);
    chk("c_out_result", {31'd0, C_OUT}, {31'd0, ec});
`ifdef ADD_OVERFLOW_EN
    chk("v_result", {31'd0, V}, {31'd0, ev});
`else
    if (ev === 1'bx) chk("v_unused", 32'd0, 32'd1);
`endif
    last_z = ez;
    last_c = ec;
  endtask

  // One idle cycle after a completion: DONE must drop and the result must hold.
  task automatic idle_check();
    @(negedge CLK);
    chk("done_fell", {31'd0, DONE}, 32'd0);
    chk("z_holds_idle", Z, last_z);
    chk("c_holds_idle", {31'd0, C_OUT}, {31'd0, last_c});
  endtask

  initial begin
    int extra;
    n_checks = 0;
    n_errors = 0;
    last_z = 32'd0;
    last_c = 1'b0;
    RST = 1'b1; START = 1'b0; X = 32'd0; Y = 32'd0; C_IN = 1'b0;

    #1;
    chk("rst_z", Z, 32'd0);
    chk("rst_c_out", {31'd0, C_OUT}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Issued on the very first edge after reset release.
    do_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    idle_check();
    do_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    idle_check();
    // Back-to-back: second START is high during the first DONE cycle.
    do_add(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    idle_check();
    // START pulsed while busy must be dropped.
    do_add(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    extra = 0;
    repeat (6) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) extra++;
    end
    chk("single_done_after_busy_start", extra, 32'd0);
    chk("z_after_busy_start", Z, 32'h2345_6789);

    do_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    idle_check();
    do_add(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    idle_check();
    do_add(32'h0102_0304, 32'h0A0B_0C0D, 1'b0, 32'h0B0D_0F11, 1'b0, 1'b0, 1'b0);
    idle_check();

    // Reset two cycles into an operation: asynchronous clear, no DONE afterwards.
    X = 32'hFFFF_FFFF; Y = 32'hFFFF_FFFF; C_IN = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_z", Z, 32'd0);
    chk("abort_c_out", {31'd0, C_OUT}, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    last_z = 32'd0;
    last_c = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) extra++;
    end
    chk("no_done_after_abort", extra, 32'd0);

    do_add(32'h80FF_7F01, 32'h7F00_80FF, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
